ps2_status_line_writer: RTL and testbench

//  Transmit-side counterpart of the keyboard line editor. On request, formats current

---
 rtl/ps2_text_pkg.sv | 46 ++++
 rtl/ps2_status_line_writer_if.sv | 32 +++
 rtl/ps2_status_line_writer_bin_to_dec3.sv | 79 +++++++
 rtl/ps2_status_line_writer.sv | 182 ++++++++++++++++++
 tb/tb_ps2_status_line_writer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_text_pkg.sv
// ps2_text_pkg
//   Shared text definitions for the PS/2 keyboard line editor and the status
//   line writer: ASCII constants, line buffer geometry, writer FSM encoding
//   and small formatting helpers.
package ps2_text_pkg;

  localparam logic [7:0] CH_V  = 8'h56;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_N  = 8'h4E;
  localparam logic [7:0] CH_G  = 8'h47;
  localparam logic [7:0] CH_F  = 8'h46;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam int LINE_BITS  = 256;
  localparam int LINE_CHARS = 32;
  // Number of characters in one status line ("VEL=ddd ANG=ddd F=f" + terminator).
  localparam int STATUS_LEN = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_CONV_V = 3'd2,
    ST_CONV_A = 3'd3,
    ST_EMIT   = 3'd4,
    ST_DONE   = 3'd5
  } writer_state_t;

  // Saturate a 32-bit unsigned value to max_value (which fits in 10 bits).
  function automatic logic [9:0] clamp_value(input logic [31:0] value,
                                             input logic [31:0] max_value);
    if (value > max_value) begin
      return max_value[9:0];
    end
    return value[9:0];
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] digit);
    return CH_0 + {4'b0000, digit};
  endfunction

endpackage

// File: rtl/ps2_status_line_writer_if.sv
// ps2_status_line_writer_if
//   Request / character-stream bundle between a client and the status line
//   writer.
//   send, velocity, angle, fire : request and launcher state (client -> writer)
//   ascii_char, char_valid      : offered character (writer -> client)
//   char_ready                  : client accepts the offered character
//   line_content, line_done     : finished packed line and its completion pulse
//   busy                        : writer is not idle
interface ps2_status_line_writer_if;
  import ps2_text_pkg::*;

  logic                 send;
  logic [31:0]          velocity;
  logic [31:0]          angle;
  logic                 fire;
  logic [7:0]           ascii_char;
  logic                 char_valid;
  logic                 char_ready;
  logic [LINE_BITS-1:0] line_content;
  logic                 line_done;
  logic                 busy;

  modport master (
    output send, velocity, angle, fire, char_ready,
    input  ascii_char, char_valid, line_content, line_done, busy
  );

  modport slave (
    input  send, velocity, angle, fire, char_ready,
    output ascii_char, char_valid, line_content, line_done, busy
  );
endinterface

// File: rtl/ps2_status_line_writer_bin_to_dec3.sv
// bin_to_dec3
//   Sequential binary to 3-digit decimal converter using repeated
//   compare-subtract (hundreds first, then tens; the remainder is the ones).
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_start          : load i_value and begin conversion (one-cycle pulse)
//   i_value          : value to convert, expected <= 999
//   o_d2, o_d1, o_d0 : hundreds, tens, ones digits; valid while o_done is high
//   o_done           : one-cycle pulse when the digits are final
module bin_to_dec3 (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [9:0] i_value,
  output logic [3:0] o_d2,
  output logic [3:0] o_d1,
  output logic [3:0] o_d0,
  output logic       o_done
);

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_HUND = 2'd1,
    PH_TENS = 2'd2
  } phase_t;

  phase_t     r_phase;
  logic [9:0] r_rem;
  logic [3:0] r_hund;
  logic [3:0] r_tens;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_phase <= PH_IDLE;
      r_rem   <= '0;
      r_hund  <= '0;
      r_tens  <= '0;
    end else if (i_start) begin
      // The load cycle already performs the first hundreds step, which keeps
      // a worst-case (999) conversion within 20 cycles including the start.
      r_tens  <= '0;
      r_phase <= PH_HUND;
      if (i_value >= 10'd100) begin
        r_rem  <= i_value - 10'd100;
        r_hund <= 4'd1;
      end else begin
        r_rem  <= i_value;
        r_hund <= 4'd0;
      end
    end else begin
      case (r_phase)
        PH_HUND: begin
          if (r_rem >= 10'd100) begin
            r_rem  <= r_rem - 10'd100;
            r_hund <= r_hund + 4'd1;
          end else begin
            r_phase <= PH_TENS;
          end
        end
        PH_TENS: begin
          if (r_rem >= 10'd10) begin
            r_rem  <= r_rem - 10'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_phase <= PH_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Done is flagged in the same cycle the remainder drops below ten, so the
  // caller can capture the digits without waiting an extra cycle.
  assign o_done = (r_phase == PH_TENS) && (r_rem < 10'd10);
  assign o_d2   = r_hund;
  assign o_d1   = r_tens;
  assign o_d0   = r_rem[3:0];

endmodule

// File: rtl/ps2_status_line_writer.sv
// ps2_status_line_writer
//   Formats the launcher state as "VEL=ddd ANG=ddd F=f<TERMINATOR>" and emits
//   it one character per accepted handshake, also building a packed copy of
//   the line (char k at [255-8k -: 8], unused bytes zero).
//   i_clock, i_reset : clock and synchronous active-high reset
//   io_line          : request inputs, character stream, packed line, status
module ps2_status_line_writer
  import ps2_text_pkg::*;
#(
  parameter int         MAX_VALUE  = 999,
  parameter logic [7:0] TERMINATOR = CH_LF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  ps2_status_line_writer_if.slave io_line
);

  localparam int         BYTE_W   = LINE_BITS / LINE_CHARS;
  localparam logic [4:0] LAST_IDX = 5'(STATUS_LEN - 1);

  writer_state_t        r_state;
  logic [9:0]           r_vel;
  logic [9:0]           r_ang;
  logic                 r_fire;
  logic [3:0]           r_v2, r_v1, r_v0;
  logic [3:0]           r_a2, r_a1, r_a0;
  logic [4:0]           r_idx;
  logic [7:0]           r_ascii;
  logic                 r_valid;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_start;
  logic [LINE_BITS-1:0] r_line;

  logic [9:0]           w_conv_value;
  logic [3:0]           w_d2, w_d1, w_d0;
  logic                 w_conv_done;
  logic [4:0]           w_next_idx;
  logic [7:0]           w_next_char;
  logic [7:0]           w_shift;
  logic [LINE_BITS-1:0] w_line_byte;

  // One converter serves both fields: velocity in CONV_V, angle in CONV_A.
  assign w_conv_value = (r_state == ST_CONV_A) ? r_ang : r_vel;

  bin_to_dec3 u_conv (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (r_start),
    .i_value (w_conv_value),
    .o_d2    (w_d2),
    .o_d1    (w_d1),
    .o_d0    (w_d0),
    .o_done  (w_conv_done)
  );

  // ascii_char is registered, so the mux looks one index ahead and the next
  // character is loaded on the same edge that accepts the current one.
  assign w_next_idx = r_idx + 5'd1;

  always_comb begin
    w_next_char = 8'h00;
    case (w_next_idx)
      5'd0:  w_next_char = CH_V;
      5'd1:  w_next_char = CH_E;
      5'd2:  w_next_char = CH_L;
      5'd3:  w_next_char = CH_EQ;
      5'd4:  w_next_char = digit_char(r_v2);
      5'd5:  w_next_char = digit_char(r_v1);
      5'd6:  w_next_char = digit_char(r_v0);
      5'd7:  w_next_char = CH_SP;
      5'd8:  w_next_char = CH_A;
      5'd9:  w_next_char = CH_N;
      5'd10: w_next_char = CH_G;
      5'd11: w_next_char = CH_EQ;
      5'd12: w_next_char = digit_char(r_a2);
      5'd13: w_next_char = digit_char(r_a1);
      5'd14: w_next_char = digit_char(r_a0);
      5'd15: w_next_char = CH_SP;
      5'd16: w_next_char = CH_F;
      5'd17: w_next_char = CH_EQ;
      5'd18: w_next_char = r_fire ? (CH_0 + 8'd1) : CH_0;
      5'd19: w_next_char = TERMINATOR;
      default: w_next_char = 8'h00;
    endcase
  end

  // The line is cleared at LATCH, so each accepted byte can simply be OR-ed
  // into its slot.
  assign w_shift     = 8'(r_idx) * 8'(BYTE_W);
  assign w_line_byte = {r_ascii, {(LINE_BITS-BYTE_W){1'b0}}} >> w_shift;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_vel   <= '0;
      r_ang   <= '0;
      r_fire  <= 1'b0;
      r_v2    <= '0;
      r_v1    <= '0;
      r_v0    <= '0;
      r_a2    <= '0;
      r_a1    <= '0;
      r_a0    <= '0;
      r_idx   <= '0;
      r_ascii <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_line  <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_line.send) begin
            r_state <= ST_LATCH;
            r_busy  <= 1'b1;
          end
        end
        ST_LATCH: begin
          r_vel   <= clamp_value(io_line.velocity, 32'(MAX_VALUE));
          r_ang   <= clamp_value(io_line.angle, 32'(MAX_VALUE));
          r_fire  <= io_line.fire;
          r_line  <= '0;
          r_start <= 1'b1;
          r_state <= ST_CONV_V;
        end
        ST_CONV_V: begin
          if (w_conv_done) begin
            r_v2    <= w_d2;
            r_v1    <= w_d1;
            r_v0    <= w_d0;
            r_start <= 1'b1;
            r_state <= ST_CONV_A;
          end
        end
        ST_CONV_A: begin
          if (w_conv_done) begin
            r_a2    <= w_d2;
            r_a1    <= w_d1;
            r_a0    <= w_d0;
            r_idx   <= '0;
            r_ascii <= CH_V;
            r_valid <= 1'b1;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (r_valid && io_line.char_ready) begin
            r_line <= r_line | w_line_byte;
            if (r_idx == LAST_IDX) begin
              r_valid <= 1'b0;
              r_ascii <= '0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_idx   <= w_next_idx;
              r_ascii <= w_next_char;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_line.ascii_char   = r_ascii;
  assign io_line.char_valid   = r_valid;
  assign io_line.line_content = r_line;
  assign io_line.line_done    = r_done;
  assign io_line.busy         = r_busy;

endmodule

// File: tb/tb_ps2_status_line_writer.sv
// tb_ps2_status_line_writer
//   Directed lines with hand-written expected text. The stimulus process
//   queues expected characters and packed lines; a monitor pops and compares
//   whenever the writer offers a character or pulses line_done.
module tb_ps2_status_line_writer;
  import ps2_text_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_status_line_writer_if bus();

  ps2_status_line_writer #(
    .MAX_VALUE  (999),
    .TERMINATOR (8'h0a)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_line (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]   exp_q[$];
  logic [255:0] line_q[$];
  int acc_in_line = 0;
  int done_seen   = 0;
  int rdy_mode    = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic push_expect(input string s);
    logic [255:0] ln;
    ln = '0;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(s[i]);
      ln[255-8*i -: 8] = s[i];
    end
    line_q.push_back(ln);
  endtask

  // Called #1 after a posedge with the writer idle; send is sampled on the next edge.
  task automatic start_line(input logic [31:0] v, input logic [31:0] a, input logic f,
                            input string s);
    push_expect(s);
    bus.velocity = v;
    bus.angle    = a;
    bus.fire     = f;
    bus.send     = 1'b1;
    @(posedge clk);
    #1;
    bus.send = 1'b0;
  endtask

  task automatic wait_first_valid(input int offset);
    int k;
    for (k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (bus.char_valid) break;
    end
    if (k > 80) begin
      n_vec++;
      n_err++;
      $display("FAIL first_valid_timeout got=none required=char_valid");
    end else begin
      chk("first_valid_latency_le_44", 256'((k + offset) <= 44), 256'(1));
    end
  endtask

  task automatic wait_line_done();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.line_done) break;
    end
    if (k == 300) begin
      n_vec++;
      n_err++;
      $display("FAIL line_done_timeout got=none required=line_done");
    end
  endtask

  task automatic back_to_idle();
    @(posedge clk);
    #1;
    chk("busy_after_done", 256'(bus.busy), 256'(0));
  endtask

  // char_ready driver: always high, or the repeating 1-0-0-1 pattern.
  initial begin
    int ph;
    ph = 0;
    bus.char_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        bus.char_ready = 1'b1;
      end else begin
        bus.char_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [7:0]   e;
    logic [255:0] el;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_in_line = 0;
      end else begin
        if (bus.char_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_char got=%02h required=no_char", bus.ascii_char);
          end else if (bus.char_ready) begin
            e = exp_q.pop_front();
            chk("char", 256'(bus.ascii_char), 256'(e));
            $display("accept idx=%0d char=%02h", acc_in_line, bus.ascii_char);
            acc_in_line++;
          end else begin
            chk("held_char", 256'(bus.ascii_char), 256'(exp_q[0]));
          end
        end
        if (bus.line_done) begin
          done_seen++;
          if (line_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_line_done got=1 required=0");
          end else begin
            el = line_q.pop_front();
            chk("line_content", bus.line_content, el);
          end
          chk("accepts_per_line", 256'(acc_in_line), 256'(20));
          chk("busy_in_done", 256'(bus.busy), 256'(1));
          acc_in_line = 0;
        end
      end
    end
  end

  initial begin
    int cnt;
    bus.send     = 1'b0;
    bus.velocity = '0;
    bus.angle    = '0;
    bus.fire     = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ascii_char", 256'(bus.ascii_char), 256'(0));
    chk("rst_char_valid", 256'(bus.char_valid), 256'(0));
    chk("rst_line_done", 256'(bus.line_done), 256'(0));
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_line_content", bus.line_content, 256'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic line, zero padding
    start_line(32'd42, 32'd7, 1'b0, "VEL=042 ANG=007 F=0\n");
    wait_first_valid(0);
    wait_line_done();
    back_to_idle();

    // 2: clamping, including bit 31 set
    start_line(32'd5000, 32'hFFFF_FFFF, 1'b1, "VEL=999 ANG=999 F=1\n");
    wait_first_valid(0);
    wait_line_done();
    back_to_idle();

    // 3: consumer stalls with 1-0-0-1 ready pattern
    rdy_mode = 1;
    start_line(32'd123, 32'd45, 1'b1, "VEL=123 ANG=045 F=1\n");
    wait_line_done();
    rdy_mode = 0;
    back_to_idle();

    // 4: send held through EMIT and DONE; only honoured in the following IDLE
    start_line(32'd7, 32'd999, 1'b0, "VEL=007 ANG=999 F=0\n");
    wait_first_valid(0);
    bus.velocity = 32'd1000;
    bus.angle    = 32'd10;
    bus.fire     = 1'b1;
    push_expect("VEL=999 ANG=010 F=1\n");
    bus.send = 1'b1;
    wait_line_done();
    @(posedge clk);
    #1;
    chk("send_ignored_in_done", 256'(bus.busy), 256'(0));
    @(posedge clk);
    #1;
    bus.send = 1'b0;
    chk("send_taken_in_idle", 256'(bus.busy), 256'(1));
    wait_line_done();
    back_to_idle();

    // 5: reset after seven accepted characters aborts the line
    start_line(32'd250, 32'd250, 1'b0, "VEL=250 ANG=250 F=0\n");
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 7; k++) begin
      @(negedge clk);
      if (bus.char_valid && bus.char_ready) cnt++;
    end
    chk("seven_accepts_seen", 256'(cnt), 256'(7));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ascii_char", 256'(bus.ascii_char), 256'(0));
    chk("abort_char_valid", 256'(bus.char_valid), 256'(0));
    chk("abort_line_done", 256'(bus.line_done), 256'(0));
    chk("abort_busy", 256'(bus.busy), 256'(0));
    chk("abort_line_content", bus.line_content, 256'(0));
    exp_q.delete();
    line_q.delete();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_abort", 256'(done_seen), 256'(5));

    // 6: inputs changed after LATCH do not affect the line
    start_line(32'd100, 32'd0, 1'b1, "VEL=100 ANG=000 F=1\n");
    @(posedge clk);
    #1;
    bus.velocity = 32'd555;
    bus.angle    = 32'd555;
    bus.fire     = 1'b0;
    wait_first_valid(1);
    wait_line_done();
    back_to_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("lines_completed", 256'(done_seen), 256'(6));
    chk("expected_queue_drained", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
